// File: rtl/ahb_sram_slave.sv
// ---------------------------------------------------------------------------
// ahb_sram_slave
//   Word-organised single-port SRAM behind a simplified AHB slave interface.
//   It serves the load/store unit's data bus. It accepts NONSEQ/SEQ transfers
//   and inserts WAIT_STATES HREADY-low cycles per OKAY data phase. Writes
//   update only the addressed byte lanes. Reads always return the full word.
//   A misaligned, oversized or out-of-range access gets a two-cycle ERROR
//   response.
//
// Ports
//   clk     : clock; all state updates on the rising edge
//   reset   : asynchronous, active-high reset
//   HSEL    : slave select
//   HADDR   : byte address (address phase)
//   HTRANS  : 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
//   HWRITE  : 1 = write, 0 = read
//   HSIZE   : 000 byte, 001 halfword, 010 word
//   HBUST   : burst type; ignored, every transfer is handled as single
//   HWDATA  : lane-positioned write data (data phase)
//   HRDATA  : read data; valid when HREADY=1 in an OKAY read data phase,
//             otherwise 0
//   HREADY  : transfer done / slave ready
//   HRESP   : 00 OKAY, 01 ERROR
// ---------------------------------------------------------------------------
module ahb_sram_slave #(
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int unsigned MEM_WORDS   = 1024,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBUST,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADY,
  output logic [1:0]  HRESP
);

  localparam int unsigned IDX_W     = $clog2(MEM_WORDS);
  // One bit wider than the bus so that the end of a window ending at 4 GiB
  // does not wrap to zero.
  localparam logic [32:0] ADDR_END  = {1'b0, ADDR_BASE} + 33'(4 * MEM_WORDS);
  localparam logic [2:0]  CNT_LOAD  = 3'(WAIT_STATES);
  localparam logic [1:0]  RESP_OKAY = 2'b00;
  localparam logic [1:0]  RESP_ERR  = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_DATA = 2'b01,
    S_ERR1 = 2'b10,
    S_ERR2 = 2'b11
  } state_e;

  // Byte-lane enables for a write with the given size and low address bits.
  function automatic logic [3:0] lane_mask(input logic [2:0] size,
                                           input logic [1:0] lo);
    logic [3:0] m;
    m = 4'b0000;
    case (size)
      3'b000:  m = 4'b0001 << lo;
      3'b001:  m = lo[1] ? 4'b1100 : 4'b0011;
      3'b010:  m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  state_e             state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [1:0]         lo_q, lo_d;
  logic               write_q, write_d;
  logic [2:0]         size_q, size_d;
  logic               hready_q, hready_d;
  logic [1:0]         hresp_q, hresp_d;
  logic [31:0]        mem_q [MEM_WORDS];

  logic [31:0]        offset_s;
  logic               valid_s;
  logic               err_s;
  logic               accept_s;
  logic               we_s;
  logic               rd_en_s;
  logic [3:0]         mask_s;
  logic               unused_s;

  // The burst type and the offset bits outside the word index carry no
  // information for this slave.
  assign offset_s = HADDR - ADDR_BASE;
  assign unused_s = ^{HBUST, offset_s[31:IDX_W+2], offset_s[1:0]};

  // A transfer is taken only while this slave itself reports ready.
  assign valid_s = HSEL & HTRANS[1] & hready_q;

  // Address-phase legality check: size, alignment and address window.
  always_comb begin
    err_s = 1'b0;
    if (HSIZE > 3'b010) begin
      err_s = 1'b1;
    end else if ((HSIZE == 3'b010) && (HADDR[1:0] != 2'b00)) begin
      err_s = 1'b1;
    end else if ((HSIZE == 3'b001) && HADDR[0]) begin
      err_s = 1'b1;
    end else if ({1'b0, HADDR} < {1'b0, ADDR_BASE}) begin
      err_s = 1'b1;
    end else if ({1'b0, HADDR} >= ADDR_END) begin
      err_s = 1'b1;
    end else begin
      err_s = 1'b0;
    end
  end

  // Next-state, wait counter, data-phase control and registered response.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    lo_d     = lo_q;
    write_d  = write_q;
    size_d   = size_q;
    accept_s = 1'b0;
    hready_d = 1'b1;
    hresp_d  = RESP_OKAY;

    case (state_q)
      S_IDLE: accept_s = 1'b1;
      S_DATA: begin
        if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end else begin
          accept_s = 1'b1;
        end
      end
      S_ERR1:  state_d = S_ERR2;
      S_ERR2:  accept_s = 1'b1;
      default: state_d = S_IDLE;
    endcase

    // Completing cycles double as the address phase of the next transfer.
    if (accept_s) begin
      if (valid_s && err_s) begin
        state_d = S_ERR1;
        cnt_d   = 3'd0;
        write_d = 1'b0;
      end else if (valid_s) begin
        state_d = S_DATA;
        cnt_d   = CNT_LOAD;
        idx_d   = offset_s[IDX_W+1:2];
        lo_d    = HADDR[1:0];
        write_d = HWRITE;
        size_d  = HSIZE;
      end else begin
        state_d = S_IDLE;
        cnt_d   = 3'd0;
      end
    end else begin
      state_d = state_d;
    end

    // The response is registered, so it is derived from the next state.
    case (state_d)
      S_IDLE: begin
        hready_d = 1'b1;
        hresp_d  = RESP_OKAY;
      end
      S_DATA: begin
        hready_d = (cnt_d == 3'd0);
        hresp_d  = RESP_OKAY;
      end
      S_ERR1: begin
        hready_d = 1'b0;
        hresp_d  = RESP_ERR;
      end
      S_ERR2: begin
        hready_d = 1'b1;
        hresp_d  = RESP_ERR;
      end
      default: begin
        hready_d = 1'b1;
        hresp_d  = RESP_OKAY;
      end
    endcase
  end

  // State and data-phase control registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 3'd0;
      idx_q    <= '0;
      lo_q     <= 2'b00;
      write_q  <= 1'b0;
      size_q   <= 3'b000;
      hready_q <= 1'b1;
      hresp_q  <= RESP_OKAY;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      lo_q     <= lo_d;
      write_q  <= write_d;
      size_q   <= size_d;
      hready_q <= hready_d;
      hresp_q  <= hresp_d;
    end
  end

  assign we_s    = (state_q == S_DATA) && (cnt_q == 3'd0) && write_q;
  assign rd_en_s = (state_q == S_DATA) && (cnt_q == 3'd0) && !write_q;
  assign mask_s  = lane_mask(size_q, lo_q);

  // SRAM write port. The array has no reset. A write still in flight when
  // reset arrives never reaches its commit edge.
  always_ff @(posedge clk) begin
    if (we_s && !reset) begin
      for (int i = 0; i < 4; i++) begin
        if (mask_s[i]) begin
          mem_q[idx_q][8*i +: 8] <= HWDATA[8*i +: 8];
        end
      end
    end
  end

  // Reads are asynchronous from the latched index. This lets a write commit
  // on the edge just before a following read's data phase.
  assign HRDATA = rd_en_s ? mem_q[idx_q] : 32'h0000_0000;
  assign HREADY = hready_q;
  assign HRESP  = hresp_q;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// ---------------------------------------------------------------------------
// tb_ahb_sram_slave
//   Two instances: index d has WAIT_STATES = d (0 and 1). Transfers are
//   queued as items. A cycle-stepped driver feeds them to one instance at a
//   time. A transfer-level model predicts HREADY/HRESP/HRDATA in every cycle
//   and keeps a word-array image of each memory.
// ---------------------------------------------------------------------------
module tb_ahb_sram_slave;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          WORDS = 64;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [1:0]       hsel_s;
  logic [1:0][31:0] haddr_s;
  logic [1:0][1:0]  htrans_s;
  logic [1:0]       hwrite_s;
  logic [1:0][2:0]  hsize_s;
  logic [1:0][2:0]  hburst_s;
  logic [1:0][31:0] hwdata_s;
  logic [1:0][31:0] hrdata_s;
  logic [1:0]       hready_s;
  logic [1:0][1:0]  hresp_s;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    ahb_sram_slave #(
      .ADDR_BASE  (BASE),
      .MEM_WORDS  (WORDS),
      .WAIT_STATES(g)
    ) u_dut (
      .clk   (clk),
      .reset (reset),
      .HSEL  (hsel_s[g]),
      .HADDR (haddr_s[g]),
      .HTRANS(htrans_s[g]),
      .HWRITE(hwrite_s[g]),
      .HSIZE (hsize_s[g]),
      .HBUST (hburst_s[g]),
      .HWDATA(hwdata_s[g]),
      .HRDATA(hrdata_s[g]),
      .HREADY(hready_s[g]),
      .HRESP (hresp_s[g])
    );
  end

  typedef struct {
    bit          gap;
    logic        sel;
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } item_t;

  item_t       q[$];
  logic [31:0] mem_m [2][WORDS];
  int          total_cnt = 0;
  int          bad_cnt   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // Illegal if the size is unsupported, the address is not a multiple of the
  // access size, or the address is outside [BASE, BASE + 4*WORDS).
  function automatic bit is_err(input logic [2:0] size, input logic [31:0] addr);
    longint a;
    longint nb;
    a = longint'(addr);
    if (size > 3'd2) return 1'b1;
    nb = longint'(1) << size;
    if ((a % nb) != 0) return 1'b1;
    if (a < longint'(BASE) || a >= longint'(BASE) + 4 * WORDS) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_write(input int d, input item_t it);
    int off;
    int w;
    int b0;
    int nb;
    off = int'(it.addr - BASE);
    w   = off / 4;
    b0  = off % 4;
    nb  = 1 << it.size;
    for (int i = b0; i < b0 + nb; i++) mem_m[d][w][8*i +: 8] = it.wdata[8*i +: 8];
  endtask

  task automatic push_xfer(input logic wr, input logic [2:0] sz,
                           input logic [31:0] ad, input logic [31:0] wd);
    item_t it;
    it.gap   = 1'b0;
    it.sel   = 1'b1;
    it.trans = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b10;
    it.write = wr;
    it.size  = sz;
    it.addr  = ad;
    it.wdata = wd;
    q.push_back(it);
  endtask

  task automatic push_gap(input logic sel, input logic [1:0] trans);
    item_t it;
    it.gap   = 1'b1;
    it.sel   = sel;
    it.trans = trans;
    it.write = 1'($urandom_range(0, 1));
    it.size  = 3'b010;
    it.addr  = BASE;
    it.wdata = 32'h0000_0000;
    q.push_back(it);
  endtask

  task automatic drive_addr(input int d, input logic sel, input logic [1:0] trans,
                            input logic wr, input logic [2:0] sz, input logic [31:0] ad);
    hsel_s[d]   = sel;
    htrans_s[d] = trans;
    hwrite_s[d] = wr;
    hsize_s[d]  = sz;
    haddr_s[d]  = ad;
    hburst_s[d] = 3'($urandom_range(0, 7));
  endtask

  // Run the queue on instance d. Checks all outputs every cycle.
  task automatic run_seq(input int d);
    item_t       cur;
    item_t       nxt;
    bit          cur_v;
    bit          cur_err;
    bit          took;
    bit          rdy_exp;
    int          cur_k;
    int          cur_len;
    int          budget;
    logic [31:0] exp_rd;
    logic [1:0]  exp_resp;
    cur_v   = 1'b0;
    cur_err = 1'b0;
    cur_k   = 0;
    cur_len = 0;
    budget  = 0;
    while ((q.size() > 0 || cur_v) && budget < 5000) begin
      budget++;
      @(posedge clk);
      #1;
      rdy_exp = !cur_v || (cur_k == cur_len - 1);
      took    = 1'b0;
      if (rdy_exp && q.size() > 0) begin
        nxt  = q.pop_front();
        took = 1'b1;
        drive_addr(d, nxt.sel, nxt.trans, nxt.write, nxt.size,
                   nxt.gap ? $urandom() : nxt.addr);
      end else if (rdy_exp) begin
        drive_addr(d, 1'b0, 2'b00, 1'b0, 3'b010, BASE);
      end else begin
        // A valid-looking request during a wait state must be ignored.
        drive_addr(d, 1'b1, 2'b10, 1'($urandom_range(0, 1)), 3'b010,
                   BASE + 32'(4 * $urandom_range(0, WORDS - 1)));
      end
      hwdata_s[d] = (cur_v && !cur_err && cur.write) ? cur.wdata : $urandom();
      @(negedge clk);
      if (!cur_v) begin
        exp_resp = 2'b00;
        exp_rd   = 32'h0000_0000;
      end else if (cur_err) begin
        exp_resp = 2'b01;
        exp_rd   = 32'h0000_0000;
      end else begin
        exp_resp = 2'b00;
        exp_rd   = (rdy_exp && !cur.write) ? mem_m[d][int'(cur.addr - BASE) / 4]
                                           : 32'h0000_0000;
      end
      check_eq($sformatf("hready%0d", d), 32'(hready_s[d]), 32'(rdy_exp));
      check_eq($sformatf("hresp%0d", d), 32'(hresp_s[d]), 32'(exp_resp));
      check_eq($sformatf("hrdata%0d", d), hrdata_s[d], exp_rd);
      if (cur_v) begin
        if (cur_k == cur_len - 1) begin
          if (!cur_err && cur.write) model_write(d, cur);
          cur_v = 1'b0;
        end else begin
          cur_k++;
        end
      end
      if (took && !nxt.gap) begin
        cur     = nxt;
        cur_v   = 1'b1;
        cur_k   = 0;
        cur_err = is_err(nxt.size, nxt.addr);
        cur_len = cur_err ? 2 : d + 1;
      end
    end
    check_eq("seq_done", 32'(q.size()) + 32'(cur_v), 32'd0);
  endtask

  task automatic push_random(input int n);
    logic [2:0]  sz;
    logic [31:0] ad;
    int          r;
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        if ($urandom_range(0, 1) == 1) push_gap(1'b0, 2'($urandom_range(0, 3)));
        else                           push_gap(1'b1, 2'($urandom_range(0, 1)));
      end else begin
        sz = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(3, 7))
                                          : 3'($urandom_range(0, 2));
        ad = BASE + 32'($urandom_range(0, 4 * WORDS - 1));
        if ($urandom_range(0, 3) != 0) ad = ad & ~((32'd1 << sz) - 32'd1);
        r = $urandom_range(0, 19);
        if (r == 0)      ad = BASE - 32'($urandom_range(1, 8));
        else if (r == 1) ad = BASE + 32'(4 * WORDS) + 32'($urandom_range(0, 8));
        else             ad = ad;
        push_xfer(1'($urandom_range(0, 1)), sz, ad, $urandom());
      end
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      drive_addr(d, 1'b0, 2'b00, 1'b0, 3'b010, BASE);
      hwdata_s[d] = 32'h0000_0000;
    end
    reset = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      check_eq("rst_hready", 32'(hready_s[d]), 32'd1);
      check_eq("rst_hresp", 32'(hresp_s[d]), 32'd0);
      check_eq("rst_hrdata", hrdata_s[d], 32'd0);
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Fill both memories with known data; back-to-back word writes.
    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < WORDS; w++) push_xfer(1'b1, 3'b010, BASE + 32'(4 * w), $urandom());
      run_seq(d);
    end

    // Word write then read with one wait state.
    push_xfer(1'b1, 3'b010, BASE + 32'd8, 32'hDEAD_BEEF);
    push_xfer(1'b0, 3'b010, BASE + 32'd8, 32'h0000_0000);
    // Byte and halfword lane merges.
    push_xfer(1'b1, 3'b010, BASE + 32'd4, 32'h1122_3344);
    push_xfer(1'b1, 3'b000, BASE + 32'd6, 32'h00AA_0000);
    push_xfer(1'b0, 3'b010, BASE + 32'd4, 32'h0000_0000);
    push_xfer(1'b1, 3'b001, BASE + 32'd4, 32'h0000_BBCC);
    push_xfer(1'b0, 3'b010, BASE + 32'd4, 32'h0000_0000);
    // Misaligned and past-the-end accesses, then confirm memory untouched.
    push_xfer(1'b0, 3'b010, BASE + 32'd2, 32'h0000_0000);
    push_xfer(1'b0, 3'b010, BASE + 32'(4 * WORDS), 32'h0000_0000);
    push_xfer(1'b1, 3'b010, BASE + 32'd2, 32'hFFFF_FFFF);
    push_xfer(1'b1, 3'b001, BASE + 32'd5, 32'hFFFF_FFFF);
    push_xfer(1'b1, 3'b011, BASE + 32'd8, 32'hFFFF_FFFF);
    push_xfer(1'b0, 3'b010, BASE + 32'd0, 32'h0000_0000);
    push_xfer(1'b0, 3'b010, BASE + 32'd4, 32'h0000_0000);
    run_seq(1);
    check_eq("merge_word", mem_m[1][1], 32'h11AA_BBCC);

    // Zero wait states: four writes then four reads, one per cycle.
    for (int i = 0; i < 4; i++) push_xfer(1'b1, 3'b010, BASE + 32'(16 + 4 * i), $urandom());
    for (int i = 0; i < 4; i++) push_xfer(1'b0, 3'b010, BASE + 32'(16 + 4 * i), 32'h0);
    push_xfer(1'b0, 3'b010, BASE - 32'd4, 32'h0);
    push_xfer(1'b0, 3'b010, BASE + 32'd16, 32'h0);
    run_seq(0);

    // Reset in the wait cycle of a write drops that write.
    @(posedge clk);
    #1;
    drive_addr(1, 1'b1, 2'b10, 1'b1, 3'b010, BASE + 32'd12);
    @(posedge clk);
    #1;
    drive_addr(1, 1'b0, 2'b00, 1'b0, 3'b010, BASE);
    hwdata_s[1] = 32'h1234_5678;
    @(negedge clk);
    check_eq("rstw_wait", 32'(hready_s[1]), 32'd0);
    #1;
    reset = 1'b1;
    #1;
    check_eq("rstw_hready", 32'(hready_s[1]), 32'd1);
    check_eq("rstw_hresp", 32'(hresp_s[1]), 32'd0);
    check_eq("rstw_hrdata", hrdata_s[1], 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    push_xfer(1'b0, 3'b010, BASE + 32'd12, 32'h0);
    run_seq(1);

    // BUSY / deselected cycles around a read.
    push_gap(1'b1, 2'b01);
    push_gap(1'b0, 2'b10);
    push_xfer(1'b0, 3'b010, BASE + 32'd20, 32'h0);
    push_gap(1'b0, 2'b11);
    push_gap(1'b1, 2'b01);
    push_gap(1'b1, 2'b00);
    push_xfer(1'b0, 3'b010, BASE + 32'd24, 32'h0);
    run_seq(1);

    // Randomized traffic on both instances.
    for (int d = 0; d < 2; d++) begin
      push_random(250);
      run_seq(d);
    end

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
